// File: rtl/neuron_mac_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : neuron_mac_ctrl
//  Purpose  : Sequences one neuron evaluation over N_INPUTS (x, weight) pairs
//             through an external combinational multiplier.  Each RUN cycle
//             fetches one pair, forwards it to the multiplier, and adds the
//             Q1.7 product into a full-width signed accumulator.  After the
//             last pair the accumulator is saturated to 8 bits and presented
//             on result with a one-cycle done pulse.
//
//  Parameters
//    N_INPUTS : number of (x, weight) pairs per evaluation, 1..16
//    ACC_W    : signed accumulator width, >= 8 + clog2(N_INPUTS)
//
//  Ports
//    clk     in   rising-edge clock
//    rst_n   in   asynchronous active-low reset
//    start   in   begin an evaluation (only looked at in IDLE)
//    in_idx  out  index of the pair currently fetched
//    x_in    in   Q1.7 input value for in_idx
//    w_in    in   Q1.7 weight for in_idx
//    mul_x   out  multiplier x operand (0 outside RUN)
//    mul_w   out  multiplier weight operand (0 outside RUN)
//    mul_p   in   multiplier product, Q1.7 (product bits [14:7])
//    busy    out  high in RUN and DONE
//    done    out  one-cycle pulse, result valid
//    result  out  saturated neuron output, Q1.7
//
//  Build option
//    NEURON_RELU_EN : when defined, negative results are clamped to 0.
//
//  Revision : 1.0  initial release
// ============================================================================
module neuron_mac_ctrl #(
    parameter int N_INPUTS = 4,
    parameter int ACC_W    = 12,
    localparam int IDX_W   = (N_INPUTS > 1) ? $clog2(N_INPUTS) : 1
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                start,
    output logic [IDX_W-1:0]    in_idx,
    input  logic signed [7:0]   x_in,
    input  logic signed [7:0]   w_in,
    output logic signed [7:0]   mul_x,
    output logic signed [7:0]   mul_w,
    input  logic signed [7:0]   mul_p,
    output logic                busy,
    output logic                done,
    output logic signed [7:0]   result
);

    // ------------------------------------------------------------------
    // Elaboration-time parameter sanity
    // ------------------------------------------------------------------
    generate
        if (N_INPUTS < 1 || N_INPUTS > 16) begin : g_bad_n_inputs
            $error("neuron_mac_ctrl: N_INPUTS must be in 1..16");
        end
        if (ACC_W < 8 + $clog2(N_INPUTS)) begin : g_bad_acc_w
            $error("neuron_mac_ctrl: ACC_W too narrow for N_INPUTS");
        end
    endgenerate

    localparam logic [IDX_W-1:0]        c_last_idx = IDX_W'(N_INPUTS - 1);
    localparam logic signed [ACC_W-1:0] c_sat_max  = ACC_W'(127);
    localparam logic signed [ACC_W-1:0] c_sat_min  = -(ACC_W'(128));

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t                     r_state;
    state_t                     w_state_next;
    logic signed [ACC_W-1:0]    r_acc;
    logic [IDX_W-1:0]           r_in_idx;
    logic signed [7:0]          r_result;

    logic signed [ACC_W-1:0]    w_p_ext;
    logic signed [ACC_W-1:0]    w_acc_next;
    logic signed [7:0]          w_sat;
    logic signed [7:0]          w_result_next;
    logic                       w_last;

    // ------------------------------------------------------------------
    // Datapath: sign-extend the product and accumulate at full width so
    // intermediate sums may exceed 8 bits; only the final value saturates.
    // ------------------------------------------------------------------
    assign w_p_ext    = ACC_W'(mul_p);
    assign w_acc_next = r_acc + w_p_ext;
    assign w_last     = (r_in_idx == c_last_idx);

    always_comb begin
        w_sat = w_acc_next[7:0];
        if (w_acc_next > c_sat_max) begin
            w_sat = 8'sd127;
        end else if (w_acc_next < c_sat_min) begin
            w_sat = -8'sd128;
        end
    end

`ifdef NEURON_RELU_EN
    assign w_result_next = w_sat[7] ? 8'sd0 : w_sat;
`else
    assign w_result_next = w_sat;
`endif

    // ------------------------------------------------------------------
    // FSM state register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // ------------------------------------------------------------------
    // FSM next state and state-decoded outputs
    // ------------------------------------------------------------------
    always_comb begin
        w_state_next = r_state;
        busy         = 1'b0;
        done         = 1'b0;
        mul_x        = 8'sd0;
        mul_w        = 8'sd0;
        case (r_state)
            S_IDLE: begin
                if (start) begin
                    w_state_next = S_RUN;
                end
            end
            S_RUN: begin
                busy  = 1'b1;
                mul_x = x_in;
                mul_w = w_in;
                if (w_last) begin
                    w_state_next = S_DONE;
                end
            end
            S_DONE: begin
                // start is deliberately not looked at here: a new
                // evaluation must be requested from IDLE.
                busy         = 1'b1;
                done         = 1'b1;
                w_state_next = S_IDLE;
            end
            default: begin
                w_state_next = S_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Accumulator, fetch index and result registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_acc    <= '0;
            r_in_idx <= '0;
            r_result <= 8'sd0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_acc    <= '0;
                        r_in_idx <= '0;
                    end
                end
                S_RUN: begin
                    r_acc <= w_acc_next;
                    if (w_last) begin
                        // Result is taken from the final sum on the same
                        // edge that enters DONE, then held until the next.
                        r_in_idx <= '0;
                        r_result <= w_result_next;
                    end else begin
                        r_in_idx <= r_in_idx + 1'b1;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign in_idx = r_in_idx;
    assign result = r_result;

endmodule
`default_nettype wire

// File: tb/tb_neuron_mac_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : tb_neuron_mac_ctrl
//  Purpose  : Self-checking bench for neuron_mac_ctrl with N_INPUTS=4.
//             Provides a combinational Q1.7 multiplier and per-index x/w
//             tables, and compares against a sum-and-clamp reference.
//  Revision : 1.0  initial release
// ============================================================================
module tb_neuron_mac_ctrl;

    localparam int N = 4;

    logic                clk;
    logic                rst_n;
    logic                start;
    logic [1:0]          in_idx;
    logic signed [7:0]   x_in;
    logic signed [7:0]   w_in;
    logic signed [7:0]   mul_x;
    logic signed [7:0]   mul_w;
    logic signed [7:0]   mul_p;
    logic                busy;
    logic                done;
    logic signed [7:0]   result;

    logic signed [7:0]   xv [N];
    logic signed [7:0]   wv [N];
    logic signed [15:0]  prod;

    int n_assert;
    int n_fail;

    neuron_mac_ctrl #(
        .N_INPUTS (N),
        .ACC_W    (12)
    ) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .start  (start),
        .in_idx (in_idx),
        .x_in   (x_in),
        .w_in   (w_in),
        .mul_x  (mul_x),
        .mul_w  (mul_w),
        .mul_p  (mul_p),
        .busy   (busy),
        .done   (done),
        .result (result)
    );

    // Environment: operand tables addressed by in_idx, Q1.7 multiplier.
    assign x_in  = xv[in_idx];
    assign w_in  = wv[in_idx];
    assign prod  = mul_x * mul_w;
    assign mul_p = prod[14:7];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input integer obs, input integer exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Reference: sum of truncated Q1.7 products, clamp to 8 bits, optional ReLU.
    function automatic integer model();
        integer s;
        integer p;
        logic signed [7:0] p8;
        s = 0;
        for (int i = 0; i < N; i++) begin
            p  = (integer'(xv[i]) * integer'(wv[i])) >>> 7;
            p8 = p[7:0];
            s  = s + integer'(p8);
        end
        if (s > 127)  s = 127;
        if (s < -128) s = -128;
`ifdef NEURON_RELU_EN
        if (s < 0) s = 0;
`endif
        return s;
    endfunction

    // One full evaluation with cycle-exact checks; called just after a posedge.
    task automatic do_eval(input string tag);
        integer exp_res;
        exp_res = model();
        @(negedge clk);
        chk({tag, ".idle_busy"}, integer'(busy), 0);
        @(posedge clk); #1;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        for (int k = 0; k < N; k++) begin
            @(negedge clk);
            chk({tag, ".run_busy"}, integer'(busy), 1);
            chk({tag, ".run_done"}, integer'(done), 0);
            chk({tag, ".idx"},      integer'(in_idx), k);
            chk({tag, ".mul_x"},    integer'(mul_x), integer'(xv[k]));
            chk({tag, ".mul_w"},    integer'(mul_w), integer'(wv[k]));
        end
        @(negedge clk);
        chk({tag, ".done"},      integer'(done), 1);
        chk({tag, ".done_busy"}, integer'(busy), 1);
        chk({tag, ".result"},    integer'(result), exp_res);
        chk({tag, ".done_mulx"}, integer'(mul_x), 0);
        @(negedge clk);
        chk({tag, ".post_done"}, integer'(done), 0);
        chk({tag, ".post_busy"}, integer'(busy), 0);
        chk({tag, ".hold"},      integer'(result), exp_res);
        chk({tag, ".idle_idx"},  integer'(in_idx), 0);
        @(posedge clk); #1;
    endtask

    task automatic set_all(input logic signed [7:0] a0, a1, a2, a3,
                           input logic signed [7:0] b0, b1, b2, b3);
        xv[0] = a0; xv[1] = a1; xv[2] = a2; xv[3] = a3;
        wv[0] = b0; wv[1] = b1; wv[2] = b2; wv[3] = b3;
    endtask

    initial begin
        int     n_done;
        bit     saw_idle;
        integer first_res;
        integer exp_res;

        n_assert = 0;
        n_fail   = 0;
        rst_n    = 1'b0;
        start    = 1'b0;
        set_all(8'sd10, 8'sd20, 8'sd30, 8'sd40, 8'sd50, 8'sd60, 8'sd70, 8'sd80);

        // Reset state
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst.busy",   integer'(busy), 0);
        chk("rst.done",   integer'(done), 0);
        chk("rst.result", integer'(result), 0);
        chk("rst.idx",    integer'(in_idx), 0);
        chk("rst.mul_x",  integer'(mul_x), 0);
        chk("rst.mul_w",  integer'(mul_w), 0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        // Saturate high: 4 x 32 = 128 -> 127
        set_all(8'sd64, 8'sd64, 8'sd64, 8'sd64, 8'sd64, 8'sd64, 8'sd64, 8'sd64);
        do_eval("sat_hi");
        // Saturate low: 4 x -32 = -128 (0 with ReLU)
        set_all(-8'sd64, -8'sd64, -8'sd64, -8'sd64, 8'sd64, 8'sd64, 8'sd64, 8'sd64);
        do_eval("sat_lo");
        // Mixed: 32 - 32 + 16 + 0 = 16
        set_all(8'sd64, -8'sd64, 8'sd32, 8'sd0, 8'sd64, 8'sd64, 8'sd64, 8'sd64);
        do_eval("mixed");
        // Full-scale corner: -128 * -128 wraps to -128 in the multiplier
        set_all(-8'sd128, 8'sd127, -8'sd128, 8'sd1, -8'sd128, 8'sd127, 8'sd127, -8'sd1);
        do_eval("corner");

        // Randomized evaluations
        for (int r = 0; r < 16; r++) begin
            for (int i = 0; i < N; i++) begin
                xv[i] = 8'($urandom_range(0, 255));
                wv[i] = 8'($urandom_range(0, 255));
            end
            do_eval("rand");
        end

        // start held high for 12 cycles -> exactly 2 evaluations
        for (int i = 0; i < N; i++) begin
            xv[i] = 8'($urandom_range(0, 255));
            wv[i] = 8'($urandom_range(0, 255));
        end
        exp_res   = model();
        n_done    = 0;
        saw_idle  = 1'b0;
        first_res = 0;
        start     = 1'b1;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            if (done) begin
                n_done++;
                chk("burst.result", integer'(result), exp_res);
                if (n_done == 1) first_res = integer'(result);
            end else if (n_done == 1) begin
                chk("burst.stable", integer'(result), first_res);
                if (!busy) saw_idle = 1'b1;
            end
            @(posedge clk); #1;
            if (c == 11) start = 1'b0;
        end
        chk("burst.n_done", n_done, 2);
        chk("burst.idle_between", integer'(saw_idle), 1);

        // Reset during RUN abandons the evaluation
        set_all(8'sd64, 8'sd64, 8'sd64, 8'sd64, 8'sd64, 8'sd64, 8'sd64, 8'sd64);
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("midrst.busy",   integer'(busy), 0);
        chk("midrst.result", integer'(result), 0);
        chk("midrst.done",   integer'(done), 0);
        chk("midrst.mul_x",  integer'(mul_x), 0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        n_done = 0;
        for (int c = 0; c < 8; c++) begin
            @(negedge clk);
            if (done || busy) n_done++;
        end
        chk("midrst.no_activity", n_done, 0);
        @(posedge clk); #1;
        set_all(8'sd64, -8'sd64, 8'sd32, 8'sd0, 8'sd64, 8'sd64, 8'sd64, 8'sd64);
        do_eval("after_rst");

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
